spectrum_line_sched: RTL and testbench
======================================

Name: spectrum_line_sched

Overview:
Controller that sequences the per-line spectrum bar renderer on the LCD pixel clock. It owns the frequency-bin counter `line_cnt` and answers each bar request with a scaled, clamped `line_length` read from a ping-pong FFT magnitude RAM. It swaps RAM banks with the FFT writer only at frame boundaries. It sits between the FFT magnitude buffer and the pixel colouring logic.

Parameters:
- NUM_LINES, 78, bars per frame; last bar row = (NUM_LINES-1)*6+8 must be < 480.
- H_LCD_DISP, 800, horizontal resolution; sets the clamp bound.
- MAG_SHIFT, 4, right shift applied to raw magnitude before clamping.

Ports:
- lcd_clk, input, 1, LCD pixel clock; the only clock.
- sys_rst_n, input, 1, synchronous active-low reset.
- frame_start, input, 1, one-cycle pulse at pixel (0,0) of each frame.
- freeze, input, 1, level; 1 inhibits bank swaps (display holds its image).
- data_req, input, 1, pulse from renderer: fetch the next bar length.
- wr_over, input, 1, pulse from renderer: current bar drawn.
- line_cnt, output, 7, current bar index.
- line_length, output, 16, bar length in pixels for the current bar.
- rd_en, output, 1, magnitude RAM read strobe.
- rd_addr, output, 8, RAM address = {rd_bank, line_cnt}.
- rd_data, input, 16, RAM read data; valid 1 cycle after rd_en.
- fft_buf_done, input, 1, pulse from FFT writer: bank wr_bank is full.
- wr_bank, output, 1, bank the FFT writer must fill; always equals ~rd_bank.
- frame_busy, output, 1, high while bars of the current frame are in progress.
- overrun, output, 1, sticky; a second fft_buf_done arrived while a swap was already pending.

Behaviour:
- Reset values (applied when sys_rst_n=0 at a lcd_clk edge):
  - line_cnt=0, line_length=0, rd_en=0, rd_bank=0 (wr_bank=1), pending=0, frame_busy=0, overrun=0.
  - State = IDLE.
  - Reset asserted mid-frame aborts immediately. No partial read completes.
- FSM states: IDLE, WAIT_REQ, READ, LATCH, WAIT_DONE.
- IDLE → WAIT_REQ on frame_start:
  - line_cnt←0, frame_busy←1.
  - Swap: if pending and !freeze, then rd_bank←~rd_bank and pending←0.
  - If fft_buf_done coincides with frame_start, it counts as pending in that same cycle and the swap occurs.
- WAIT_REQ → READ on data_req. In READ: rd_en=1 for exactly one cycle; rd_addr={rd_bank,line_cnt}.
- READ → LATCH, unconditionally. In LATCH:
  - line_length←min(rd_data>>MAG_SHIFT, H_LCD_DISP-1).
  - Arithmetic is 16-bit unsigned; the compare is unsigned.
- Latency: line_length is valid 3 cycles after data_req (the edge ending LATCH). This is well inside horizontal blanking.
- LATCH → WAIT_DONE, unconditionally.
- WAIT_DONE on wr_over:
  - If line_cnt==NUM_LINES-1: line_cnt←0, frame_busy←0, line_length←0, go to IDLE.
  - Else: line_cnt←line_cnt+1, go to WAIT_REQ.
  - line_cnt never exceeds NUM_LINES-1.
- Spurious pulses:
  - data_req outside WAIT_REQ is ignored.
  - wr_over outside WAIT_DONE is ignored.
  - frame_start outside IDLE is ignored; the frame continues and the next swap waits for the next frame_start after IDLE.
- fft_buf_done handling:
  - Sets pending.
  - If pending is already 1, also sets overrun. The swap is still a single toggle.
  - overrun clears only on reset.
- freeze=1 keeps pending set; the swap happens at the first frame_start after freeze drops.
- line_length holds its value between updates.

Decomposition:
- Package lcd_spec_pkg holds:
  - the state enum;
  - constants LINE_PITCH=6 and LINE_OFFSET=8;
  - H_LCD_DISP;
  - the RAM address width (8).
- One natural sub-module, bank_swap_ctrl, holds the pending, overrun, rd_bank and freeze logic; it is driven by frame_start and fft_buf_done.
- The FSM and the scale/clamp stay in the top.

Test Plan:
- Reset, frame_start, then data_req with rd_data=0x0800, MAG_SHIFT=4 → rd_en at +1 with rd_addr=0x00; line_length=128 at +3; after wr_over, line_cnt=1.
- rd_data=0xFFFF → line_length=799 (clamped); rd_data=0x000F → line_length=0.
- Full frame with 78 req/over pairs → line_cnt runs 0..77, returns to 0, frame_busy falls on the 78th wr_over; a 79th data_req is ignored (no rd_en).
- fft_buf_done mid-frame, then frame_start → rd_bank=1, wr_bank=0, rd_addr MSB=1 on the next read; two fft_buf_done before frame_start → overrun=1, exactly one toggle.
- freeze=1 across two frame_starts with pending → no swap; freeze=0, next frame_start → swap.
- sys_rst_n=0 for 1 cycle while in LATCH at line_cnt=40 → all outputs return to reset values the next cycle; state IDLE; subsequent frame_start starts at line 0.

Source files
------------

// File: rtl/lcd_spec_pkg.sv
// Shared types and constants for the LCD spectrum bar display.
package lcd_spec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      READ,
      LATCH,
      WAIT_DONE
   } state_t;

   // Bar row geometry: bar n is drawn at row n*LINE_PITCH + LINE_OFFSET.
   localparam int LINE_PITCH  = 6;
   localparam int LINE_OFFSET = 8;

   localparam int H_LCD_DISP  = 800;

   // Magnitude RAM address: {bank, bin}.
   localparam int ADDR_W      = 8;

   // Scale a raw FFT magnitude down and clamp it to the visible width.
   function automatic logic [15:0] scale_clamp(input logic [15:0] raw,
                                               input int          shift,
                                               input logic [15:0] lim);
      logic [15:0] s;
      s = raw >> shift;
      return (s > lim) ? lim : s;
   endfunction

endpackage

// File: rtl/bank_swap_ctrl.sv
// Ping-pong bank ownership between the FFT writer and the bar reader.
// A finished FFT buffer is parked as "pending" until the next accepted
// frame start, so the displayed bank never changes mid-frame.
module bank_swap_ctrl (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start,   // already qualified: only pulses when a frame is accepted
   input  logic freeze,
   input  logic fft_buf_done,
   output logic rd_bank,
   output logic overrun
);

   logic pending;
   logic have_buf;

   // A done pulse coinciding with the frame start still counts for this swap.
   assign have_buf = pending | fft_buf_done;

   // Pending/overrun tracking and the single-toggle bank swap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_bank <= 1'b0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (fft_buf_done && pending)
            overrun <= 1'b1;
         if (frame_start && have_buf && !freeze) begin
            rd_bank <= ~rd_bank;
            pending <= 1'b0;
         end else if (fft_buf_done) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/spectrum_line_sched.sv
// Per-bar sequencer: walks the frequency bins of one frame, fetches each
// magnitude from the ping-pong RAM and hands a scaled, clamped bar length
// to the renderer.
module spectrum_line_sched #(
   parameter int NUM_LINES  = 78,
   parameter int H_LCD_DISP = lcd_spec_pkg::H_LCD_DISP,
   parameter int MAG_SHIFT  = 4
) (
   input  logic                            lcd_clk,
   input  logic                            sys_rst_n,
   input  logic                            frame_start,
   input  logic                            freeze,
   input  logic                            data_req,
   input  logic                            wr_over,
   output logic [6:0]                      line_cnt,
   output logic [15:0]                     line_length,
   output logic                            rd_en,
   output logic [lcd_spec_pkg::ADDR_W-1:0] rd_addr,
   input  logic [15:0]                     rd_data,
   input  logic                            fft_buf_done,
   output logic                            wr_bank,
   output logic                            frame_busy,
   output logic                            overrun
);

   import lcd_spec_pkg::*;

   localparam logic [6:0]  LAST_LINE = 7'(NUM_LINES - 1);
   localparam logic [15:0] LEN_MAX   = 16'(H_LCD_DISP - 1);

   state_t state_q, state_d;
   logic   start_ok;
   logic   latch_en;
   logic   advance;
   logic   last_line;
   logic   rd_bank;

   assign last_line = (line_cnt == LAST_LINE);
   assign rd_addr   = {rd_bank, line_cnt};
   assign wr_bank   = ~rd_bank;

   bank_swap_ctrl u_bank (
      .clk          (lcd_clk),
      .rst_n        (sys_rst_n),
      .frame_start  (start_ok),
      .freeze       (freeze),
      .fft_buf_done (fft_buf_done),
      .rd_bank      (rd_bank),
      .overrun      (overrun)
   );

   // State register.
   always_ff @(posedge lcd_clk) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Next state and per-state strobes; stray pulses fall through untouched.
   always_comb begin
      state_d  = state_q;
      rd_en    = 1'b0;
      start_ok = 1'b0;
      latch_en = 1'b0;
      advance  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               start_ok = 1'b1;
               state_d  = WAIT_REQ;
            end
         end
         WAIT_REQ: begin
            if (data_req) state_d = READ;
         end
         READ: begin
            rd_en   = 1'b1;
            state_d = LATCH;
         end
         LATCH: begin
            latch_en = 1'b1;
            state_d  = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wr_over) begin
               advance = 1'b1;
               state_d = last_line ? IDLE : WAIT_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bin counter, frame flag and bar length registers.
   always_ff @(posedge lcd_clk) begin
      if (!sys_rst_n) begin
         line_cnt    <= '0;
         line_length <= '0;
         frame_busy  <= 1'b0;
      end else begin
         if (start_ok) begin
            line_cnt   <= '0;
            frame_busy <= 1'b1;
         end
         if (latch_en)
            line_length <= scale_clamp(rd_data, MAG_SHIFT, LEN_MAX);
         if (advance) begin
            if (last_line) begin
               line_cnt    <= '0;
               frame_busy  <= 1'b0;
               line_length <= '0;
            end else begin
               line_cnt <= line_cnt + 7'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spectrum_line_sched.sv
// Bench for spectrum_line_sched: frame-level reference model compared every
// cycle, plus literal expectations at the interesting points.
module tb_spectrum_line_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start, freeze, data_req, wr_over, fft_buf_done;
   logic [6:0]  line_cnt;
   logic [15:0] line_length;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data = 16'h0;
   logic        wr_bank, frame_busy, overrun;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:255];

   always #5 clk = ~clk;

   spectrum_line_sched dut (
      .lcd_clk      (clk),
      .sys_rst_n    (rst_n),
      .frame_start  (frame_start),
      .freeze       (freeze),
      .data_req     (data_req),
      .wr_over      (wr_over),
      .line_cnt     (line_cnt),
      .line_length  (line_length),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .fft_buf_done (fft_buf_done),
      .wr_bank      (wr_bank),
      .frame_busy   (frame_busy),
      .overrun      (overrun)
   );

   // Registered magnitude RAM.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int bar_len(input int raw);
      int v;
      v = raw / 16;
      return (v > 799) ? 799 : v;
   endfunction

   // ---------------- reference model (frame/bar level) ----------------
   bit m_ok = 0;
   bit m_busy, m_bank, m_pend, m_ovr, m_drawn;
   int m_line, m_len, m_age;   // m_age: 0 none, 1 fetch issued, 2 data arriving
   bit have;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ok = 1; m_busy = 0; m_bank = 0; m_pend = 0; m_ovr = 0;
         m_drawn = 0; m_line = 0; m_len = 0; m_age = 0;
      end else if (m_ok) begin
         have = m_pend || fft_buf_done;
         if (fft_buf_done && m_pend) m_ovr = 1;
         if (!m_busy && frame_start) begin
            m_busy = 1; m_line = 0;
            if (have && !freeze) begin m_bank = !m_bank; m_pend = 0; end
            else m_pend = have;
         end else begin
            if (fft_buf_done) m_pend = 1;
            if (m_busy) begin
               if (m_age == 2) begin
                  m_len = bar_len(int'(mem[m_bank * 128 + m_line]));
                  m_age = 0; m_drawn = 1;
               end else if (m_age == 1) begin
                  m_age = 2;
               end else if (!m_drawn && data_req) begin
                  m_age = 1;
               end else if (m_drawn && wr_over) begin
                  m_drawn = 0;
                  if (m_line == 77) begin m_busy = 0; m_line = 0; m_len = 0; end
                  else m_line++;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("line_cnt", int'(line_cnt), m_line);
         chk("line_length", int'(line_length), m_len);
         chk("rd_en", int'(rd_en), int'(m_busy && m_age == 1));
         if (m_busy && m_age == 1)
            chk("rd_addr", int'(rd_addr), m_bank * 128 + m_line);
         chk("wr_bank", int'(wr_bank), int'(!m_bank));
         chk("frame_busy", int'(frame_busy), int'(m_busy));
         chk("overrun", int'(overrun), int'(m_ovr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic fs();   frame_start = 1;  @(negedge clk); frame_start = 0;  endtask
   task automatic req();  data_req = 1;     @(negedge clk); data_req = 0;     endtask
   task automatic over(); wr_over = 1;      @(negedge clk); wr_over = 0;      endtask
   task automatic done(); fft_buf_done = 1; @(negedge clk); fft_buf_done = 0; endtask
   task automatic tick(input int n); repeat (n) @(negedge clk); endtask
   task automatic bar(); req(); tick(2); over(); endtask
   task automatic bars(input int n); for (int i = 0; i < n; i++) bar(); endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'((i * 613 + 37) & 16'hFFFF);
      for (int i = 128; i < 256; i++) mem[i] = 16'((i - 128) * 300);
      mem[0] = 16'h0800; mem[1] = 16'hFFFF; mem[2] = 16'h000F;

      rst_n = 0; frame_start = 0; freeze = 0; data_req = 0; wr_over = 0; fft_buf_done = 0;
      tick(3);
      rst_n = 1;
      chk("rst line_cnt", int'(line_cnt), 0);
      chk("rst line_length", int'(line_length), 0);
      chk("rst rd_en", int'(rd_en), 0);
      chk("rst wr_bank", int'(wr_bank), 1);
      chk("rst frame_busy", int'(frame_busy), 0);
      chk("rst overrun", int'(overrun), 0);

      // First bar: 0x0800 >> 4 = 128
      fs();
      chk("busy after start", int'(frame_busy), 1);
      req();
      chk("rd_en +1", int'(rd_en), 1);
      chk("rd_addr +1", int'(rd_addr), 0);
      tick(2);
      chk("len 0x0800", int'(line_length), 128);
      over();
      chk("line_cnt after over", int'(line_cnt), 1);

      // Clamp and underflow-to-zero
      req(); tick(2);
      chk("len 0xFFFF", int'(line_length), 799);
      over();
      req(); tick(2);
      chk("len 0x000F", int'(line_length), 0);
      over();

      // Rest of the frame with stray pulses mixed in
      for (int l = 3; l < 78; l++) begin
         if (l == 5) begin over(); tick(1); end
         if (l == 9) begin fs(); tick(1); end
         req(); tick(2);
         if (l == 6) begin req(); tick(1); end
         over();
      end
      chk("end line_cnt", int'(line_cnt), 0);
      chk("end frame_busy", int'(frame_busy), 0);
      chk("end line_length", int'(line_length), 0);
      req();
      chk("79th req ignored", int'(rd_en), 0);
      tick(2);

      // One buffer done mid-frame, swap at next frame start
      fs(); tick(3); done(); tick(1); bars(78);
      fs();
      chk("swap wr_bank", int'(wr_bank), 0);
      req();
      chk("rd_addr bank1", int'(rd_addr), 8'h80);
      tick(2); over(); bars(77);

      // Two dones before frame start: overrun, single toggle
      done(); tick(1); done();
      chk("overrun set", int'(overrun), 1);
      fs();
      chk("single toggle", int'(wr_bank), 1);
      bars(78);

      // Freeze holds the pending swap across frames
      done(); freeze = 1;
      fs();
      chk("freeze hold 1", int'(wr_bank), 1);
      bars(78);
      fs();
      chk("freeze hold 2", int'(wr_bank), 1);
      bars(78);
      freeze = 0;
      fs();
      chk("unfreeze swap", int'(wr_bank), 0);
      bars(78);

      // Done coinciding with frame start swaps immediately
      frame_start = 1; fft_buf_done = 1; @(negedge clk); frame_start = 0; fft_buf_done = 0;
      chk("coincident swap", int'(wr_bank), 1);
      bars(78);

      // Reset while latching bar 40
      fs(); bars(40);
      req(); tick(1);
      rst_n = 0; tick(1); rst_n = 1;
      chk("mid rst line_cnt", int'(line_cnt), 0);
      chk("mid rst line_length", int'(line_length), 0);
      chk("mid rst rd_en", int'(rd_en), 0);
      chk("mid rst busy", int'(frame_busy), 0);
      chk("mid rst wr_bank", int'(wr_bank), 1);
      chk("mid rst overrun", int'(overrun), 0);
      req();
      chk("idle after rst", int'(rd_en), 0);
      tick(1);
      fs(); req();
      chk("restart rd_en", int'(rd_en), 1);
      chk("restart rd_addr", int'(rd_addr), 0);
      tick(2);
      chk("restart len", int'(line_length), 128);
      over(); tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
